// File: rtl/if_id_skid_latch.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_latch
// Description : IF/ID boundary register with a 2-entry skid buffer. IF hands
//               over {npc, instr} under valid/ready; ID sees registered
//               outputs. in_ready depends only on the state register, so
//               there is no combinational path from out_ready to in_ready.
//               Includes branch flush and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_latch #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_npc,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_npc,
  output logic [DATA_W-1:0] out_instr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INSTR);

  state_t              state_q;
  logic [DATA_W-1:0]   main_npc_q;
  logic [DATA_W-1:0]   main_instr_q;
  logic [DATA_W-1:0]   skid_npc_q;
  logic [DATA_W-1:0]   skid_instr_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d;
  logic                in_fire;
  logic                out_fire;

  // Handshake flags are decoded from the state register only.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_npc   = main_npc_q;
  assign out_instr = main_instr_q;
  assign stall_cnt = stall_cnt_q;

  // Next stall count: count stalled cycles, sticking at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Occupancy FSM with main (head) and skid entries; reset beats flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q      <= ST_EMPTY;
      main_npc_q   <= '0;
      main_instr_q <= NOP_W;
      skid_npc_q   <= '0;
      skid_instr_q <= NOP_W;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_npc_q   <= in_npc;
            main_instr_q <= in_instr;
            state_q      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_npc_q   <= in_npc;
            main_instr_q <= in_instr;
          end else if (in_fire) begin
            skid_npc_q   <= in_npc;
            skid_instr_q <= in_instr;
            state_q      <= ST_FULL;
          end else if (out_fire) begin
            main_npc_q   <= '0;
            main_instr_q <= NOP_W;
            state_q      <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Input is blocked here, so only a drain can change state.
          if (out_fire) begin
            main_npc_q   <= skid_npc_q;
            main_instr_q <= skid_instr_q;
            skid_npc_q   <= '0;
            skid_instr_q <= NOP_W;
            state_q      <= ST_ONE;
          end
        end
        default: begin
          state_q      <= ST_EMPTY;
          main_npc_q   <= '0;
          main_instr_q <= NOP_W;
        end
      endcase
    end
  end

  // Stall counter is cleared by reset only; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire
